// File: rtl/insn_queue.sv
// Circular instruction queue between decode/rename and issue: up to ENQ_W
// compacted writes per cycle, a 4-entry age-ordered read window at the head.
module insn_queue #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned ENTRY_W = 64,
    parameter int unsigned ENQ_W   = 2
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          flush,
    input  logic [ENQ_W-1:0]              enq_valid,
    input  logic [ENQ_W-1:0][ENTRY_W-1:0] enq_insns,
    output logic                          enq_ready,
    input  logic                          ext_enable,
    input  logic [1:0]                    ext_consumed,
    output logic [3:0]                    ext_valid,
    output logic [3:0][ENTRY_W-1:0]       insns,
    output logic                          empty
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);
    localparam logic [PW:0] ENQ_C   = (PW+1)'(ENQ_W);

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]      r_head;
    logic [PW-1:0]      r_tail;
    logic [PW:0]        r_count;

    logic               w_do_enq;
    logic [PW:0]        w_n_enq;
    logic [PW:0]        w_n_req;
    logic [PW:0]        w_n_deq;
    logic [PW-1:0]      w_off;
    logic [ENQ_W-1:0]   w_wr_en;
    logic [PW-1:0]      w_wr_addr [ENQ_W];

    assign enq_ready = (DEPTH_C - r_count) >= ENQ_C;
    assign empty     = (r_count == '0);
    assign w_do_enq  = enq_ready && !flush;

    // Set enq_valid slots are packed in slot order starting at tail.
    always_comb begin
        w_off   = '0;
        w_n_enq = '0;
        w_wr_en = '0;
        for (int unsigned k = 0; k < ENQ_W; k++) begin
            w_wr_addr[k] = r_tail + w_off;
            w_wr_en[k]   = w_do_enq && enq_valid[k];
            if (enq_valid[k]) begin
                w_off = w_off + PW'(1);
            end
        end
        if (w_do_enq) begin
            w_n_enq = (PW+1)'(w_off);
        end
    end

    // Over-consume saturates at the live count.
    always_comb begin
        w_n_req = ext_enable ? ((PW+1)'(ext_consumed) + (PW+1)'(1)) : '0;
        w_n_deq = (w_n_req > r_count) ? r_count : w_n_req;
    end

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            ext_valid[i] = r_count > (PW+1)'(i);
            insns[i]     = r_mem[r_head + PW'(i)];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PW'(w_n_deq);
            r_tail  <= r_tail + PW'(w_n_enq);
            r_count <= r_count + w_n_enq - w_n_deq;
        end
    end

    always_ff @(posedge clock) begin
        for (int unsigned k = 0; k < ENQ_W; k++) begin
            if (w_wr_en[k]) begin
                r_mem[w_wr_addr[k]] <= enq_insns[k];
            end
        end
    end
endmodule

// File: tb/tb_insn_queue.sv
// Randomized and directed bench for insn_queue, checked against an
// age-ordered queue model of the live entries.
module tb_insn_queue;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned ENTRY_W = 64;
    localparam int unsigned ENQ_W   = 2;

    logic                          clock;
    logic                          reset_n;
    logic                          flush;
    logic [ENQ_W-1:0]              enq_valid;
    logic [ENQ_W-1:0][ENTRY_W-1:0] enq_insns;
    logic                          enq_ready;
    logic                          ext_enable;
    logic [1:0]                    ext_consumed;
    logic [3:0]                    ext_valid;
    logic [3:0][ENTRY_W-1:0]       insns;
    logic                          empty;

    insn_queue #(.DEPTH(DEPTH), .ENTRY_W(ENTRY_W), .ENQ_W(ENQ_W)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .flush       (flush),
        .enq_valid   (enq_valid),
        .enq_insns   (enq_insns),
        .enq_ready   (enq_ready),
        .ext_enable  (ext_enable),
        .ext_consumed(ext_consumed),
        .ext_valid   (ext_valid),
        .insns       (insns),
        .empty       (empty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [ENTRY_W-1:0] q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic check_outputs();
        logic [3:0] exp_v;
        for (int i = 0; i < 4; i++) exp_v[i] = (q.size() > i);
        check("ext_valid", 64'(ext_valid), 64'(exp_v));
        check("empty", 64'(empty), 64'(q.size() == 0));
        check("enq_ready", 64'(enq_ready), 64'((DEPTH - q.size()) >= ENQ_W));
        for (int i = 0; i < 4; i++) begin
            if (q.size() > i) check($sformatf("insns%0d", i), insns[i], q[i]);
        end
    endtask

    // One clock: check current outputs, advance model, cross the edge.
    task automatic step();
        int unsigned n_req;
        int unsigned n_deq;
        bit ready;
        @(negedge clock);
        check_outputs();
        if (flush) begin
            q.delete();
        end else begin
            ready = (DEPTH - q.size()) >= ENQ_W;
            n_req = ext_enable ? int'(ext_consumed) + 1 : 0;
            n_deq = (n_req > q.size()) ? q.size() : n_req;
            for (int unsigned i = 0; i < n_deq; i++) void'(q.pop_front());
            if (ready) begin
                for (int k = 0; k < ENQ_W; k++) begin
                    if (enq_valid[k]) q.push_back(enq_insns[k]);
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [1:0] ev, input logic en, input logic [1:0] cons, input logic fl);
        enq_valid    = ev;
        enq_insns[0] = rnd64();
        enq_insns[1] = rnd64();
        ext_enable   = en;
        ext_consumed = cons;
        flush        = fl;
        step();
    endtask

    initial begin
        reset_n = 1'b0;
        flush = 1'b0; enq_valid = '0; enq_insns = '0;
        ext_enable = 1'b0; ext_consumed = '0;
        #2;
        check("rst_ext_valid", 64'(ext_valid), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_enq_ready", 64'(enq_ready), 64'd1);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // A,B written together, then visible next cycle
        enq_valid = 2'b11; enq_insns[0] = 64'hAAAA_0000_0000_000A; enq_insns[1] = 64'hBBBB_0000_0000_000B;
        step();
        enq_valid = 2'b00;
        step();
        check("ab_valid", 64'(ext_valid), 64'b0011);
        check("ab_insn0", insns[0], 64'hAAAA_0000_0000_000A);
        check("ab_insn1", insns[1], 64'hBBBB_0000_0000_000B);

        // Fill: extra enq dropped once fewer than two free slots
        drive(2'b00, 1'b0, 2'd0, 1'b1);
        for (int i = 0; i < 10; i++) drive(2'b11, 1'b0, 2'd0, 1'b0);
        check("full_ready", 64'(enq_ready), 64'd0);
        check("full_valid", 64'(ext_valid), 64'hF);
        drive(2'b00, 1'b1, 2'd3, 1'b0);
        check("after_deq_ready", 64'(enq_ready), 64'd1);
        check("after_deq_qsize", 64'(q.size()), 64'd12);

        // Walk head to 14 then straddle the wrap point
        drive(2'b00, 1'b0, 2'd0, 1'b1);
        for (int i = 0; i < 7; i++) drive(2'b11, 1'b0, 2'd0, 1'b0);
        for (int i = 0; i < 3; i++) drive(2'b00, 1'b1, 2'd3, 1'b0);
        drive(2'b00, 1'b1, 2'd1, 1'b0);
        drive(2'b11, 1'b0, 2'd0, 1'b0);
        drive(2'b11, 1'b0, 2'd0, 1'b0);
        drive(2'b00, 1'b0, 2'd0, 1'b0);
        check("wrap_valid", 64'(ext_valid), 64'hF);

        // count=5: enq 2 and consume 2 in one cycle
        drive(2'b00, 1'b0, 2'd0, 1'b1);
        drive(2'b11, 1'b0, 2'd0, 1'b0);
        drive(2'b11, 1'b0, 2'd0, 1'b0);
        drive(2'b10, 1'b0, 2'd0, 1'b0);
        drive(2'b11, 1'b1, 2'd1, 1'b0);
        drive(2'b00, 1'b0, 2'd0, 1'b0);
        check("same_cycle_qsize", 64'(q.size()), 64'd5);

        // count=2, over-consume 4
        drive(2'b00, 1'b0, 2'd0, 1'b1);
        drive(2'b11, 1'b0, 2'd0, 1'b0);
        drive(2'b00, 1'b1, 2'd3, 1'b0);
        drive(2'b00, 1'b0, 2'd0, 1'b0);
        check("underflow_empty", 64'(empty), 64'd1);
        drive(2'b01, 1'b0, 2'd0, 1'b0);
        drive(2'b00, 1'b0, 2'd0, 1'b0);

        // Flush with enq and consume at count=9
        drive(2'b00, 1'b0, 2'd0, 1'b1);
        for (int i = 0; i < 4; i++) drive(2'b11, 1'b0, 2'd0, 1'b0);
        drive(2'b01, 1'b0, 2'd0, 1'b0);
        drive(2'b11, 1'b1, 2'd0, 1'b1);
        check("flush_valid", 64'(ext_valid), 64'd0);
        check("flush_empty", 64'(empty), 64'd1);

        // Random traffic with occasional flush and an async reset mid-stream
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                for (int i = 0; i < 6; i++) drive(2'b11, 1'b0, 2'd0, 1'b0);
                reset_n = 1'b0;
                #1;
                check("async_rst_valid", 64'(ext_valid), 64'd0);
                check("async_rst_empty", 64'(empty), 64'd1);
                check("async_rst_ready", 64'(enq_ready), 64'd1);
                q.delete();
                enq_valid = '0; ext_enable = 1'b0; flush = 1'b0;
                @(negedge clock);
                reset_n = 1'b1;
                @(posedge clock);
                #1;
            end
            drive(2'($urandom), 1'($urandom_range(0, 2) != 0), 2'($urandom), 1'($urandom_range(0, 40) == 0));
        end
        drive(2'b00, 1'b0, 2'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
